// File: rtl/motoro3_pkg.sv
// Shared types and constants for the six-step commutation sequencer.
// Drive words are ordered {aE, bE, cE, aL, bL, cL}.
package motoro3_pkg;

    localparam int M3_CNT_W = 25;

    localparam logic [M3_CNT_W-1:0] M3_START_PERIOD = 25'd1_000_000;
    localparam logic [M3_CNT_W-1:0] M3_RUN_PERIOD   = 25'd20_000;
    localparam logic [M3_CNT_W-1:0] M3_RAMP_DEC     = 25'd10_000;
    localparam logic [M3_CNT_W-1:0] M3_ALIGN_CYCLES = 25'd5_000_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_RAMP,
        ST_RUN,
        ST_FAULT
    } state_t;

    // One-hot high side in bits 5:3, one-hot low side in bits 2:0.
    localparam logic [5:0] STEP_TABLE [6] = '{
        6'b100_010,
        6'b100_001,
        6'b010_001,
        6'b010_100,
        6'b001_100,
        6'b001_010
    };

    function automatic logic [2:0] next_step(input logic [2:0] cur, input logic rev);
        if (rev) begin
            return (cur == 3'd0) ? 3'd5 : cur - 3'd1;
        end
        return (cur >= 3'd5) ? 3'd0 : cur + 3'd1;
    endfunction

endpackage

// File: rtl/motoro3_commutation_sequencer_if.sv
// Control inputs and drive/timer outputs of the commutation sequencer.
interface motoro3_commutation_sequencer_if
    import motoro3_pkg::*;
#(
    parameter int CNT_W = M3_CNT_W
);
    logic             run;
    logic             dir;
    logic             fault;
    logic             aE;
    logic             bE;
    logic             cE;
    logic             aL;
    logic             bL;
    logic             cL;
    logic [CNT_W-1:0] m3cnt;
    logic             m3cntLast1;
    logic [2:0]       step;
    logic             running;

    modport master (
        output run, dir, fault,
        input  aE, bE, cE, aL, bL, cL, m3cnt, m3cntLast1, step, running
    );

    modport slave (
        input  run, dir, fault,
        output aE, bE, cE, aL, bL, cL, m3cnt, m3cntLast1, step, running
    );

endinterface

// File: rtl/motoro3_step_decoder.sv
// Combinational step index to phase drive pattern; all-off when inactive.
module motoro3_step_decoder
    import motoro3_pkg::*;
(
    input  logic [2:0] step,
    input  logic       active,
    output logic [5:0] drive
);

    always_comb begin
        drive = '0;
        if (active && step <= 3'd5) begin
            drive = STEP_TABLE[step];
        end
    end

endmodule

// File: rtl/motoro3_commutation_sequencer.sv
// Open-loop six-step commutation sequencer with period ramp.
// Define MOTORO3_ALIGN_EN to hold step 0 for ALIGN_CYCLES before ramping.
module motoro3_commutation_sequencer
    import motoro3_pkg::*;
#(
    parameter int               CNT_W        = M3_CNT_W,
    parameter logic [CNT_W-1:0] START_PERIOD = M3_START_PERIOD,
    parameter logic [CNT_W-1:0] RUN_PERIOD   = M3_RUN_PERIOD,
    parameter logic [CNT_W-1:0] RAMP_DEC     = M3_RAMP_DEC,
    parameter logic [CNT_W-1:0] ALIGN_CYCLES = M3_ALIGN_CYCLES
) (
    input logic clk,
    input logic rst,
    motoro3_commutation_sequencer_if.slave bus
);

`ifdef MOTORO3_ALIGN_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam state_t           START_STATE = ALIGN_EN ? ST_ALIGN : ST_RAMP;
    localparam logic [CNT_W-1:0] FIRST_LOAD  = ALIGN_EN ? (ALIGN_CYCLES - ONE) : (START_PERIOD - ONE);

    state_t           state, state_nxt;
    logic [2:0]       step_q, step_nxt;
    logic [CNT_W-1:0] period_q, period_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             last_q;
    logic             running_q;
    logic [5:0]       drive_q, drive_nxt;
    logic             active_nxt;
    logic [CNT_W:0]   diff;
    logic [CNT_W-1:0] ramped;

    // Next ramp period: one decrement, clamped to the run period on borrow or undershoot.
    always_comb begin
        diff   = {1'b0, period_q} - {1'b0, RAMP_DEC};
        ramped = RUN_PERIOD;
        if (!diff[CNT_W] && diff[CNT_W-1:0] >= RUN_PERIOD) begin
            ramped = diff[CNT_W-1:0];
        end
    end

    always_comb begin
        state_nxt  = state;
        step_nxt   = step_q;
        period_nxt = period_q;
        cnt_nxt    = cnt_q;
        case (state)
            ST_IDLE: begin
                if (bus.fault) begin
                    state_nxt = ST_FAULT;
                end else if (bus.run) begin
                    state_nxt = START_STATE;
                    step_nxt  = 3'd0;
                    cnt_nxt   = FIRST_LOAD;
                end
            end
            ST_ALIGN, ST_RAMP, ST_RUN: begin
                if (bus.fault || !bus.run) begin
                    state_nxt  = bus.fault ? ST_FAULT : ST_IDLE;
                    cnt_nxt    = '0;
                    period_nxt = START_PERIOD;
                end else if (cnt_q == '0) begin
                    step_nxt = next_step(step_q, bus.dir);
                    if (state == ST_ALIGN) begin
                        state_nxt = ST_RAMP;
                        cnt_nxt   = START_PERIOD - ONE;
                    end else if (state == ST_RAMP) begin
                        period_nxt = ramped;
                        cnt_nxt    = ramped - ONE;
                        if (ramped == RUN_PERIOD) begin
                            state_nxt = ST_RUN;
                        end
                    end else begin
                        cnt_nxt = period_q - ONE;
                    end
                end else begin
                    cnt_nxt = cnt_q - ONE;
                end
            end
            ST_FAULT: begin
                // Restart requires run to have been released as well as the fault.
                if (!bus.fault && !bus.run) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        active_nxt = (state_nxt == ST_ALIGN) || (state_nxt == ST_RAMP) || (state_nxt == ST_RUN);
    end

    motoro3_step_decoder u_decoder (
        .step   (step_nxt),
        .active (active_nxt),
        .drive  (drive_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            step_q    <= 3'd0;
            period_q  <= START_PERIOD;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            running_q <= 1'b0;
            drive_q   <= '0;
        end else begin
            state     <= state_nxt;
            step_q    <= step_nxt;
            period_q  <= period_nxt;
            cnt_q     <= cnt_nxt;
            last_q    <= active_nxt && (cnt_nxt == '0);
            running_q <= (state_nxt == ST_RUN);
            drive_q   <= drive_nxt;
        end
    end

    assign {bus.aE, bus.bE, bus.cE, bus.aL, bus.bL, bus.cL} = drive_q;
    assign bus.m3cnt      = cnt_q;
    assign bus.m3cntLast1 = last_q;
    assign bus.step       = step_q;
    assign bus.running    = running_q;

endmodule

// File: tb/tb_motoro3_commutation_sequencer.sv
// Randomized bench for three sequencer configurations against a step-length model.
module tb_motoro3_commutation_sequencer;

    localparam int N = 3;
    localparam int P_START [N] = '{10, 10, 3};
    localparam int P_RUN   [N] = '{4, 4, 4};
    localparam int P_DEC   [N] = '{3, 8, 3};
    localparam int P_ALIGN     = 6;
    localparam int HI [6] = '{0, 0, 1, 1, 2, 2};
    localparam int LO [6] = '{1, 2, 2, 0, 0, 1};

`ifdef MOTORO3_ALIGN_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic run;
    logic dir;
    logic fault;

    always #5 clk = ~clk;

    motoro3_commutation_sequencer_if if0 ();
    motoro3_commutation_sequencer_if if1 ();
    motoro3_commutation_sequencer_if if2 ();

    assign if0.run = run;  assign if0.dir = dir;  assign if0.fault = fault;
    assign if1.run = run;  assign if1.dir = dir;  assign if1.fault = fault;
    assign if2.run = run;  assign if2.dir = dir;  assign if2.fault = fault;

    motoro3_commutation_sequencer #(
        .START_PERIOD(25'd10), .RUN_PERIOD(25'd4), .RAMP_DEC(25'd3), .ALIGN_CYCLES(25'd6)
    ) dut0 (.clk(clk), .rst(rst), .bus(if0));

    motoro3_commutation_sequencer #(
        .START_PERIOD(25'd10), .RUN_PERIOD(25'd4), .RAMP_DEC(25'd8), .ALIGN_CYCLES(25'd6)
    ) dut1 (.clk(clk), .rst(rst), .bus(if1));

    motoro3_commutation_sequencer #(
        .START_PERIOD(25'd3), .RUN_PERIOD(25'd4), .RAMP_DEC(25'd3), .ALIGN_CYCLES(25'd6)
    ) dut2 (.clk(clk), .rst(rst), .bus(if2));

    logic [5:0]  obs_drv  [N];
    logic [24:0] obs_cnt  [N];
    logic [2:0]  obs_step [N];
    logic        obs_last [N];
    logic        obs_run  [N];

    assign obs_drv[0]  = {if0.aE, if0.bE, if0.cE, if0.aL, if0.bL, if0.cL};
    assign obs_drv[1]  = {if1.aE, if1.bE, if1.cE, if1.aL, if1.bL, if1.cL};
    assign obs_drv[2]  = {if2.aE, if2.bE, if2.cE, if2.aL, if2.bL, if2.cL};
    assign obs_cnt[0]  = if0.m3cnt;       assign obs_cnt[1]  = if1.m3cnt;       assign obs_cnt[2]  = if2.m3cnt;
    assign obs_step[0] = if0.step;        assign obs_step[1] = if1.step;        assign obs_step[2] = if2.step;
    assign obs_last[0] = if0.m3cntLast1;  assign obs_last[1] = if1.m3cntLast1;  assign obs_last[2] = if2.m3cntLast1;
    assign obs_run[0]  = if0.running;     assign obs_run[1]  = if1.running;     assign obs_run[2]  = if2.running;

    // mode: 0 stopped, 1 spinning, 2 faulted; a step lasts len cycles, elapsed counts up.
    typedef struct {
        int mode;
        int step;
        int len;
        int elapsed;
        int period;
        bit aligning;
        bit at_speed;
    } mdl_t;

    mdl_t m [N];
    int   checks = 0;
    int   errors = 0;

    function automatic mdl_t mdl_reset(input int start);
        mdl_t r;
        r.mode = 0; r.step = 0; r.len = 0; r.elapsed = 0;
        r.period = start; r.aligning = 1'b0; r.at_speed = 1'b0;
        return r;
    endfunction

    function automatic mdl_t mdl_tick(input mdl_t s, input int i, input bit r_run, input bit r_dir, input bit r_fault);
        mdl_t n;
        n = s;
        if (s.mode == 2) begin
            if (!r_fault && !r_run) n.mode = 0;
        end else if (r_fault) begin
            n.mode = 2;
        end else if (s.mode == 1 && !r_run) begin
            n.mode = 0;
        end else if (s.mode == 0 && r_run) begin
            n.mode = 1; n.step = 0; n.elapsed = 0;
            n.period = P_START[i]; n.aligning = ALIGN_EN; n.at_speed = 1'b0;
            n.len = ALIGN_EN ? P_ALIGN : P_START[i];
        end else if (s.mode == 1) begin
            if (s.elapsed == s.len - 1) begin
                n.step = r_dir ? (s.step + 5) % 6 : (s.step + 1) % 6;
                n.elapsed = 0;
                if (s.aligning) begin
                    n.aligning = 1'b0;
                end else if (!s.at_speed) begin
                    n.period = (s.period - P_DEC[i] > P_RUN[i]) ? s.period - P_DEC[i] : P_RUN[i];
                    n.at_speed = (n.period == P_RUN[i]);
                end
                n.len = n.period;
            end else begin
                n.elapsed = s.elapsed + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [5:0] exp_drive(input mdl_t s);
        logic [5:0] d;
        d = '0;
        if (s.mode == 1) begin
            d[5 - HI[s.step]] = 1'b1;
            d[2 - LO[s.step]] = 1'b1;
        end
        return d;
    endfunction

    task automatic check_one(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d t=%0t observed=%0h expected=%0h", tag, i, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            bit spin;
            spin = (m[i].mode == 1);
            check_one("m3cnt", i, 32'(obs_cnt[i]), spin ? 32'(m[i].len - 1 - m[i].elapsed) : 32'd0);
            check_one("step", i, 32'(obs_step[i]), 32'(m[i].step));
            check_one("drive", i, 32'(obs_drv[i]), 32'(exp_drive(m[i])));
            check_one("last", i, 32'(obs_last[i]), 32'(spin && (m[i].elapsed == m[i].len - 1)));
            check_one("running", i, 32'(obs_run[i]), 32'(spin && m[i].at_speed));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int i = 0; i < N; i++) m[i] = mdl_tick(m[i], i, run, dir, fault);
        #1;
        check_all();
    endtask

    initial begin
        run = 1'b0; dir = 1'b0; fault = 1'b0; rst = 1'b0;
        for (int i = 0; i < N; i++) m[i] = mdl_reset(P_START[i]);
        #1 rst = 1'b1;
        #2 check_all();
        @(negedge clk) rst = 1'b0;
        repeat (2) cycle();

        // forward spin-up through the whole ramp
        run = 1'b1;
        repeat (60) cycle();

        // occasional direction changes
        repeat (120) begin
            if ($urandom_range(0, 9) == 0) dir = ~dir;
            cycle();
        end

        // stop and restart at random points
        repeat (4) begin
            run = 1'b1;
            repeat ($urandom_range(5, 40)) cycle();
            run = 1'b0;
            repeat ($urandom_range(1, 3)) cycle();
        end
        run = 1'b1;
        repeat (60) cycle();

        // fault while running; must stay latched until run is released
        fault = 1'b1;
        repeat (2) cycle();
        fault = 1'b0;
        repeat (3) cycle();
        run = 1'b0;
        cycle();
        run = 1'b1;
        repeat (40) cycle();

        // random mix of run, fault and direction
        repeat (600) begin
            run   = ($urandom_range(0, 49) != 0);
            fault = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) dir = 1'($urandom_range(0, 1));
            cycle();
        end

        // asynchronous reset in the middle of a step
        fault = 1'b0;
        run = 1'b1;
        repeat (50) cycle();
        #2 rst = 1'b1;
        for (int i = 0; i < N; i++) m[i] = mdl_reset(P_START[i]);
        #1 check_all();
        @(negedge clk) rst = 1'b0;
        run = 1'b0;
        cycle();
        run = 1'b1;
        repeat (30) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/motoro3_commutation_sequencer.md
Name: motoro3_commutation_sequencer

Overview:
Six-step commutation sequencer for the 3-phase motor drive; sits directly upstream of the PWM generator. It produces the high-side phase enables aE/bE/cE and the matching low-side enables. It also produces the 25-bit step timer m3cnt and the end-of-step strobe m3cntLast1, which the PWM stage uses to reload its counters. It runs open-loop with a start-up alignment phase, then ramps the step period down to a run period.

Parameters:
CNT_W, 25, width of step timer and period values
START_PERIOD, 25'd1_000_000, first ramp step length in clk cycles (100 ms @ 10 MHz)
RUN_PERIOD, 25'd20_000, final steady step length (2 ms)
RAMP_DEC, 25'd10_000, period decrement applied after each ramp step
ALIGN_CYCLES, 25'd5_000_000, alignment hold length (used only with the optional feature)

Ports:
clk  in  1  system clock, 10 MHz
rst  in  1  asynchronous active-high reset
run  in  1  level; 1 = spin motor, 0 = stop
dir  in  1  0 = forward (step+1), 1 = reverse (step-1)
fault  in  1  level; over-current/driver fault
aE  out  1  phase A high-side (PWM) enable
bE  out  1  phase B high-side (PWM) enable
cE  out  1  phase C high-side (PWM) enable
aL  out  1  phase A low-side on
bL  out  1  phase B low-side on
cL  out  1  phase C low-side on
m3cnt  out  CNT_W  step timer, counts down to 0
m3cntLast1  out  1  high during the last cycle of every step (m3cnt==0 while active)
step  out  3  current step index 0..5
running  out  1  1 in RUN state

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous, active-high.
- Reset values:
  - state=IDLE, step=0, cur_period=START_PERIOD.
  - m3cnt=0; m3cntLast1, running and all six enables = 0.
- All outputs are registered.
- States: IDLE, ALIGN, RAMP, RUN, FAULT.
- Step table (high/low):
  - 0: A/B; 1: A/C; 2: B/C; 3: B/A; 4: C/A; 5: C/B.
  - Exactly one E and one L are high in ALIGN/RAMP/RUN; all six are 0 in IDLE/FAULT.
- IDLE:
  - On run=1 and fault=0, go to ALIGN (or RAMP, see feature).
  - Set step=0 and load m3cnt = ALIGN_CYCLES-1 (or START_PERIOD-1).
- Step timing:
  - m3cnt decrements by 1 each cycle.
  - In the cycle with m3cnt==0, m3cntLast1=1.
  - Next cycle: step advances (dir=0: (step+1) mod 6, 5→0; dir=1: (step-1) mod 6, 0→5) and m3cnt reloads to cur_period-1.
  - Each step therefore lasts exactly cur_period cycles.
  - dir is sampled only at step boundaries.
- ALIGN:
  - Holds step 0 for ALIGN_CYCLES cycles, with m3cntLast1 on the last cycle.
  - Then goes to RAMP with the step advanced once and m3cnt=START_PERIOD-1.
- RAMP:
  - At each step end, cur_period <= cur_period-RAMP_DEC, saturating at RUN_PERIOD.
  - If the difference would be < RUN_PERIOD or would borrow, use RUN_PERIOD.
  - The new period applies to the next step.
  - When the updated value equals RUN_PERIOD, go to RUN.
  - If START_PERIOD<=RUN_PERIOD, enter RUN after the first step.
- RUN: fixed cur_period; running=1.
- run=0 (any active state):
  - Next cycle: IDLE, all enables 0, m3cnt=0, m3cntLast1=0, cur_period=START_PERIOD.
  - No step completion occurs on that cycle.
- fault=1:
  - Highest priority, from any state except FAULT.
  - Next cycle: FAULT, outputs as in IDLE.
  - FAULT exits to IDLE only when fault=0 and run=0 in the same cycle; run must drop before restart.
- Simultaneous fault and run=0: FAULT.
- Simultaneous step end and run=0: IDLE wins, step not advanced.

Optional Feature:
MOTORO3_ALIGN_EN
- Defined: IDLE→ALIGN, rotor aligned on step 0 for ALIGN_CYCLES before RAMP.
- Undefined: IDLE→RAMP directly with step=0 and m3cnt=START_PERIOD-1. The ALIGN state and ALIGN_CYCLES are unused, and the first step end advances to step 1.

Decomposition:
- Package motoro3_pkg holds:
  - state enum (IDLE, ALIGN, RAMP, RUN, FAULT);
  - 6-entry step table constants (high/low one-hot);
  - CNT_W and default period constants.
- Sub-module motoro3_step_decoder: purely combinational, step index → {aE,bE,cE,aL,bL,cL}, 000000 when inactive. Its outputs are registered in the parent.

Test Plan:
All scenarios use START_PERIOD=10, RUN_PERIOD=4, RAMP_DEC=3, ALIGN_CYCLES=6, feature defined.
1. Reset asserted mid-RUN → same cycle async: all enables 0, m3cnt=0, step=0, running=0.
2. run=1, dir=0 → ALIGN:
   - step 0 (aE=1,bL=1) for 6 cycles, m3cntLast1 on the 6th;
   - then steps 1,2,3,4 with lengths 10,7,4,4;
   - running=1 from the first 4-cycle step.
3. dir=1 → step sequence 0 (align),5,4,3…; toggling dir mid-step changes direction only at the next m3cntLast1 boundary.
4. run dropped mid-RAMP with m3cnt=5 → next cycle all enables 0, m3cnt=0; run=1 again → restart in ALIGN with period back to 10.
5. fault=1 in RUN → FAULT next cycle, outputs 0; fault=0 with run=1 stays FAULT; run=0 → IDLE.
6. RAMP_DEC=8 → step lengths 10 then 4 (saturated, no underflow); START_PERIOD=3 → RUN after the first step with period 4.
